mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised MEM->WB pipeline register for the 16-bit core.
//  - Adds a valid bit, stall (hold) and flush (bubble) control.
//  - Muxes the write-back data (ALU result or memory result).
//  - Fires the register-file write exactly once per instruction, even when stalled.
//  - Keeps a one-entry history of the last committed write, used for ID-stage bypass.
//  - Keeps saturating retire and bubble counters.
//  Sits between the memory-access stage and the register file.
// PARAMETERS
//  DATA_W  16  width of alures, memres and write-back data
//  REG_AW  4   destination register address width
//  CNT_W   16  width of the retire and bubble counters
// PORTS
//  CLK            in   1       clock; all state updates on posedge
//  RST            in   1       synchronous reset, active-high
//  stall_i        in   1       hold the current stage contents
//  flush_i        in   1       replace the stage contents with a bubble
//  valid_i        in   1       MEM stage holds a real instruction
//  memtoreg_i     in   1       1: write back memres; 0: write back alures
//  regdst_i       in   REG_AW  destination register
//  regwrite_i     in   1       instruction writes the register file
//  alures_i       in   DATA_W  ALU result
//  memres_i       in   DATA_W  memory read data
//  valid_o        out  1       stage holds a real instruction
//  memtoreg_o     out  1       registered memtoreg
//  regdst_o       out  REG_AW  registered regdst
//  regwrite_o     out  1       registered regwrite (already qualified by valid)
//  alures_o       out  DATA_W  registered alures
//  memres_o       out  DATA_W  registered memres
//  wbdata_o       out  DATA_W  memtoreg_o ? memres_o : alures_o (combinational from regs)
//  wb_we_o        out  1       register-file write enable
//  hist_valid_o   out  1       a write committed in the previous cycle
//  hist_regdst_o  out  REG_AW  register written in the previous cycle
//  hist_data_o    out  DATA_W  data written in the previous cycle
//  retire_cnt_o   out  CNT_W   instructions retired (saturating)
//  bubble_cnt_o   out  CNT_W   cycles with valid_o=0 (saturating)
// BEHAVIOUR
//  - Reset: when RST=1 at posedge, every register and output is 0, including
//    the fresh bit, history and counters. Reset is honoured mid-stall or mid-flush.
//  - Update priority: RST > flush_i > stall_i > load.
//  - Latency: 1 cycle from MEM inputs to registered outputs.
//  - Load (no stall, no flush): capture all *_i.
//    - valid_o <= valid_i.
//    - regwrite_o <= regwrite_i & valid_i.
//    - fresh <= 1.
//  - Stall: all stage registers hold; fresh <= 0.
//  - Flush: valid_o, regwrite_o, memtoreg_o, regdst_o, alures_o, memres_o and
//    fresh all <= 0. Flush wins over a simultaneous stall.
//  - Write enable: wb_we_o = valid_o & regwrite_o & fresh.
//    - It is high only in the first cycle an entry is present.
//    - A stalled entry is never written twice.
//  - History update on every non-reset posedge:
//    - hist_valid_o <= wb_we_o.
//    - When wb_we_o=1: hist_regdst_o <= regdst_o and hist_data_o <= wbdata_o;
//      otherwise both hold their values.
//    - Flush does not clear history, because that write has already committed.
//  - retire_cnt_o increments on each posedge where valid_o & fresh
//    (once per instruction); it saturates at 2^CNT_W-1.
//  - bubble_cnt_o increments on each non-reset posedge where valid_o=0;
//    it saturates at 2^CNT_W-1.
// TESTING
//  - Load: RST, then valid=1, regwrite=1, regdst=5, memtoreg=0, alures=0x1234.
//    Next cycle: wbdata_o=0x1234, wb_we_o=1.
//    Cycle after: hist_valid_o=1, hist_regdst_o=5, hist_data_o=0x1234.
//  - Memory data: memtoreg=1, memres=0xBEEF, alures=0x0001 -> wbdata_o=0xBEEF.
//  - Stall: load regdst=3, then stall_i=1 for 3 cycles.
//    Outputs are held; wb_we_o=1 only in the first cycle; retire_cnt_o rises by exactly 1.
//  - Flush over stall: flush_i=1 and stall_i=1 together ->
//    next cycle valid_o=0, wb_we_o=0, bubble_cnt_o+1, history unchanged.
//  - Saturation: CNT_W=4, 20 consecutive bubble cycles -> bubble_cnt_o=15 and it holds there.
//  - Reset mid-stall: RST=1 during a stall with valid data held ->
//    next cycle all outputs, history and counters are 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with one-shot write enable, write history and saturating counters
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              memtoreg_i,
  input  logic [REG_AW-1:0] regdst_i,
  input  logic              regwrite_i,
  input  logic [DATA_W-1:0] alures_i,
  input  logic [DATA_W-1:0] memres_i,
  output logic              valid_o,
  output logic              memtoreg_o,
  output logic [REG_AW-1:0] regdst_o,
  output logic              regwrite_o,
  output logic [DATA_W-1:0] alures_o,
  output logic [DATA_W-1:0] memres_o,
  output logic [DATA_W-1:0] wbdata_o,
  output logic              wb_we_o,
  output logic              hist_valid_o,
  output logic [REG_AW-1:0] hist_regdst_o,
  output logic [DATA_W-1:0] hist_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  logic              valid_q, valid_d;
  logic              memtoreg_q, memtoreg_d;
  logic [REG_AW-1:0] regdst_q, regdst_d;
  logic              regwrite_q, regwrite_d;
  logic [DATA_W-1:0] alures_q, alures_d;
  logic [DATA_W-1:0] memres_q, memres_d;
  logic              fresh_q, fresh_d;
  logic              hist_valid_q, hist_valid_d;
  logic [REG_AW-1:0] hist_regdst_q, hist_regdst_d;
  logic [DATA_W-1:0] hist_data_q, hist_data_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              load;
  always_comb begin
    load          = ~flush_i & ~stall_i;
    wb_we_o       = valid_q & regwrite_q & fresh_q;
    wbdata_o      = memtoreg_q ? memres_q : alures_q;
    valid_d       = flush_i ? 1'b0 : load ? valid_i : valid_q;
    memtoreg_d    = flush_i ? 1'b0 : load ? memtoreg_i : memtoreg_q;
    regdst_d      = flush_i ? '0 : load ? regdst_i : regdst_q;
    regwrite_d    = flush_i ? 1'b0 : load ? (regwrite_i & valid_i) : regwrite_q;
    alures_d      = flush_i ? '0 : load ? alures_i : alures_q;
    memres_d      = flush_i ? '0 : load ? memres_i : memres_q;
    // fresh marks the first cycle an entry is present, so a held entry writes only once
    fresh_d       = load;
    hist_valid_d  = wb_we_o;
    hist_regdst_d = wb_we_o ? regdst_q : hist_regdst_q;
    hist_data_d   = wb_we_o ? wbdata_o : hist_data_q;
    retire_d      = (valid_q & fresh_q & ~&retire_q) ? retire_q + CNT_W'(1) : retire_q;
    bubble_d      = (~valid_q & ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q       <= 1'b0;
      memtoreg_q    <= 1'b0;
      regdst_q      <= '0;
      regwrite_q    <= 1'b0;
      alures_q      <= '0;
      memres_q      <= '0;
      fresh_q       <= 1'b0;
      hist_valid_q  <= 1'b0;
      hist_regdst_q <= '0;
      hist_data_q   <= '0;
      retire_q      <= '0;
      bubble_q      <= '0;
    end else begin
      valid_q       <= valid_d;
      memtoreg_q    <= memtoreg_d;
      regdst_q      <= regdst_d;
      regwrite_q    <= regwrite_d;
      alures_q      <= alures_d;
      memres_q      <= memres_d;
      fresh_q       <= fresh_d;
      hist_valid_q  <= hist_valid_d;
      hist_regdst_q <= hist_regdst_d;
      hist_data_q   <= hist_data_d;
      retire_q      <= retire_d;
      bubble_q      <= bubble_d;
    end
  end
  assign valid_o       = valid_q;
  assign memtoreg_o    = memtoreg_q;
  assign regdst_o      = regdst_q;
  assign regwrite_o    = regwrite_q;
  assign alures_o      = alures_q;
  assign memres_o      = memres_q;
  assign hist_valid_o  = hist_valid_q;
  assign hist_regdst_o = hist_regdst_q;
  assign hist_data_o   = hist_data_q;
  assign retire_cnt_o  = retire_q;
  assign bubble_cnt_o  = bubble_q;
endmodule
